// File: rtl/enc_pkg.sv
// Shared definitions for the 8-to-3 serializing encoder: FSM states,
// fixed widths and a popcount helper used on the load path.
package enc_pkg;

   localparam int N  = 8;
   localparam int AW = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Number of set bits in an 8-bit request vector (0..8).
   function automatic logic [AW:0] popcount8(input logic [N-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-bit priority encoder. HI_FIRST selects whether the
// highest or the lowest set bit wins; any_o flags a non-zero vector.
module pri_enc8 #(
   parameter bit HI_FIRST = 1'b1
) (
   input  logic [7:0] vec_i,
   output logic [2:0] idx_o,
   output logic       any_o
);

   // Scan in ascending or descending order so the last hit is the winner.
   always_comb begin
      idx_o = 3'd0;
      any_o = |vec_i;
      if (HI_FIRST) begin
         for (int i = 0; i < 8; i++) begin
            if (vec_i[i]) idx_o = 3'(i);
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 3'(i);
         end
      end
   end

endmodule

// File: rtl/enc_serializer_8to3.sv
// Captures a multi-hot request vector and replays it as a stream of
// binary indices, one per V/RDY handshake, in priority order.
module enc_serializer_8to3
   import enc_pkg::*;
#(
   parameter bit HI_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          E,
   input  logic          LD,
   input  logic [N-1:0]  D,
   output logic          LD_RDY,
   output logic [AW-1:0] Y,
   output logic          V,
   input  logic          RDY,
   output logic [AW:0]   PCNT,
   output logic          DONE
);

   state_t        state_q, state_d;
   logic [N-1:0]  pend_q, pend_d;
   logic [AW-1:0] y_q, y_d;
   logic          v_q, v_d;
   logic [AW:0]   pcnt_q, pcnt_d;
   logic          done_q, done_d;

   logic [N-1:0]  pend_clr;
   logic [AW-1:0] ld_idx, nx_idx;
   logic          ld_any, nx_any;

   // Pending set as it would look once the current index is accepted.
   assign pend_clr = pend_q & ~(8'b1 << y_q);

   pri_enc8 #(.HI_FIRST(HI_FIRST)) u_ld_enc (
      .vec_i (D),
      .idx_o (ld_idx),
      .any_o (ld_any)
   );

   pri_enc8 #(.HI_FIRST(HI_FIRST)) u_nx_enc (
      .vec_i (pend_clr),
      .idx_o (nx_idx),
      .any_o (nx_any)
   );

   // Next-state logic: load in IDLE, serve/stall/freeze in BUSY.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      y_d     = y_q;
      v_d     = v_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (E && LD && ld_any) begin
               pend_d  = D;
               pcnt_d  = popcount8(D);
               y_d     = ld_idx;
               v_d     = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!E) begin
               v_d = 1'b0;
            end else if (v_q && RDY) begin
               pend_d = pend_clr;
               pcnt_d = pcnt_q - 4'd1;
               if (nx_any) begin
                  y_d = nx_idx;
               end else begin
                  y_d     = '0;
                  v_d     = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (!v_q) begin
               // Enable returned: re-present the held index.
               v_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         y_q     <= '0;
         v_q     <= 1'b0;
         pcnt_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         y_q     <= y_d;
         v_q     <= v_d;
         pcnt_q  <= pcnt_d;
         done_q  <= done_d;
      end
   end

   assign LD_RDY = (state_q == ST_IDLE);
   assign Y      = y_q;
   assign V      = v_q;
   assign PCNT   = pcnt_q;
   assign DONE   = done_q;

endmodule

// File: tb/tb_enc_serializer_8to3.sv
module tb_enc_serializer_8to3;

   logic       clk, rst, E, LD, RDY;
   logic [7:0] D;
   logic       rdy_h, v_h, done_h, rdy_l, v_l, done_l;
   logic [2:0] y_h, y_l;
   logic [3:0] pc_h, pc_l;

   int checks = 0;
   int failures = 0;

   // Behavioural reference: index 0 = HI_FIRST=0 instance, 1 = HI_FIRST=1.
   logic       m_busy [2];
   logic [7:0] m_pend [2];
   logic [2:0] m_y    [2];
   logic       m_v    [2];
   logic       m_done [2];

   enc_serializer_8to3 #(.HI_FIRST(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .E(E), .LD(LD), .D(D), .LD_RDY(rdy_h),
      .Y(y_h), .V(v_h), .RDY(RDY), .PCNT(pc_h), .DONE(done_h)
   );

   enc_serializer_8to3 #(.HI_FIRST(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .E(E), .LD(LD), .D(D), .LD_RDY(rdy_l),
      .Y(y_l), .V(v_l), .RDY(RDY), .PCNT(pc_l), .DONE(done_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] pick(input logic [7:0] p, input int hi);
      logic [2:0] r;
      r = 3'd0;
      if (hi != 0) begin
         for (int i = 7; i >= 0; i--) if (p[i]) begin r = 3'(i); break; end
      end else begin
         for (int i = 0; i < 8; i++) if (p[i]) begin r = 3'(i); break; end
      end
      return r;
   endfunction

   task automatic model_step(input int h);
      m_done[h] = 1'b0;
      if (rst) begin
         m_busy[h] = 0; m_pend[h] = 0; m_y[h] = 0; m_v[h] = 0;
      end else if (!m_busy[h]) begin
         if (E && LD && D != 8'h00) begin
            m_busy[h] = 1; m_pend[h] = D; m_y[h] = pick(D, h); m_v[h] = 1;
         end
      end else if (!E) begin
         m_v[h] = 0;
      end else if (m_v[h] && RDY) begin
         m_pend[h][m_y[h]] = 1'b0;
         if (m_pend[h] != 0) m_y[h] = pick(m_pend[h], h);
         else begin
            m_busy[h] = 0; m_v[h] = 0; m_y[h] = 0; m_done[h] = 1;
         end
      end else if (!m_v[h]) begin
         m_v[h] = 1;
      end
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; E = 1; LD = 1; D = 8'hFF; RDY = 1;
      tick(); tick();
      rst = 0; LD = 0;
      checks++; if (v_h !== 1'b0)   begin failures++; $display("FAIL reset_v got=%0b exp=0", v_h); end
      checks++; if (rdy_h !== 1'b1) begin failures++; $display("FAIL reset_ldrdy got=%0b exp=1", rdy_h); end
      checks++; if (pc_h !== 4'd0)  begin failures++; $display("FAIL reset_pcnt got=%0d exp=0", pc_h); end
      checks++; if (done_h !== 1'b0 || y_h !== 3'd0) begin failures++; $display("FAIL reset_done_y got=%0b/%0d exp=0/0", done_h, y_h); end
   endtask

   task automatic test_hi_a5();
      logic [2:0] exp_y [4];
      exp_y = '{3'd7, 3'd5, 3'd2, 3'd0};
      E = 1; RDY = 1; LD = 1; D = 8'hA5;
      tick();
      LD = 0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (y_h !== exp_y[k] || v_h !== 1'b1) begin failures++; $display("FAIL a5_y%0d got=%0d/v%0b exp=%0d/v1", k, y_h, v_h, exp_y[k]); end
         checks++; if (pc_h !== 4'(4 - k)) begin failures++; $display("FAIL a5_pcnt%0d got=%0d exp=%0d", k, pc_h, 4 - k); end
         checks++; if (done_h !== 1'b0) begin failures++; $display("FAIL a5_early_done%0d got=%0b exp=0", k, done_h); end
         tick();
      end
      checks++; if (done_h !== 1'b1 || rdy_h !== 1'b1 || v_h !== 1'b0) begin failures++; $display("FAIL a5_done got=d%0b r%0b v%0b exp=d1 r1 v0", done_h, rdy_h, v_h); end
      tick();
      checks++; if (done_h !== 1'b0 || pc_h !== 4'd0) begin failures++; $display("FAIL a5_done_pulse got=d%0b pc%0d exp=d0 pc0", done_h, pc_h); end
   endtask

   task automatic test_lo_stall();
      E = 1; RDY = 0; LD = 1; D = 8'h81;
      tick();
      LD = 0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (y_l !== 3'd0 || v_l !== 1'b1 || pc_l !== 4'd2) begin failures++; $display("FAIL lo_stall%0d got=y%0d v%0b pc%0d exp=y0 v1 pc2", k, y_l, v_l, pc_l); end
         tick();
      end
      RDY = 1;
      checks++; if (y_l !== 3'd0 || v_l !== 1'b1) begin failures++; $display("FAIL lo_hold got=y%0d v%0b exp=y0 v1", y_l, v_l); end
      tick();
      checks++; if (y_l !== 3'd7 || v_l !== 1'b1 || pc_l !== 4'd1) begin failures++; $display("FAIL lo_second got=y%0d v%0b pc%0d exp=y7 v1 pc1", y_l, v_l, pc_l); end
      tick();
      checks++; if (done_l !== 1'b1 || v_l !== 1'b0 || rdy_l !== 1'b1) begin failures++; $display("FAIL lo_done got=d%0b v%0b r%0b exp=d1 v0 r1", done_l, v_l, rdy_l); end
      tick();
   endtask

   task automatic test_ignored_loads();
      E = 1; RDY = 1; LD = 1; D = 8'h00;
      tick();
      checks++; if (v_h !== 1'b0 || rdy_h !== 1'b1 || pc_h !== 4'd0 || done_h !== 1'b0) begin failures++; $display("FAIL zero_load got=v%0b r%0b pc%0d d%0b exp=v0 r1 pc0 d0", v_h, rdy_h, pc_h, done_h); end
      E = 0; D = 8'h55;
      tick(); tick();
      checks++; if (v_h !== 1'b0 || rdy_h !== 1'b1 || pc_h !== 4'd0 || done_h !== 1'b0) begin failures++; $display("FAIL e0_load got=v%0b r%0b pc%0d d%0b exp=v0 r1 pc0 d0", v_h, rdy_h, pc_h, done_h); end
      E = 1; LD = 0;
   endtask

   task automatic test_enable_drop();
      E = 1; RDY = 1; LD = 1; D = 8'h3C;
      tick();
      LD = 0; E = 0;
      tick(); tick();
      checks++; if (v_h !== 1'b0 || y_h !== 3'd5 || pc_h !== 4'd4) begin failures++; $display("FAIL edrop_frozen got=v%0b y%0d pc%0d exp=v0 y5 pc4", v_h, y_h, pc_h); end
      E = 1;
      tick();
      checks++; if (v_h !== 1'b1 || y_h !== 3'd5 || pc_h !== 4'd4) begin failures++; $display("FAIL edrop_resume got=v%0b y%0d pc%0d exp=v1 y5 pc4", v_h, y_h, pc_h); end
      tick();
      checks++; if (y_h !== 3'd4 || pc_h !== 4'd3) begin failures++; $display("FAIL edrop_next got=y%0d pc%0d exp=y4 pc3", y_h, pc_h); end
      for (int k = 0; k < 20 && !(rdy_h && rdy_l); k++) tick();
      checks++; if (!(rdy_h && rdy_l)) begin failures++; $display("FAIL edrop_drain got=r%0b%0b exp=r11", rdy_h, rdy_l); end
   endtask

   task automatic test_ld_busy();
      E = 1; RDY = 1; LD = 1; D = 8'h11;
      tick();
      checks++; if (y_h !== 3'd4 || pc_h !== 4'd2) begin failures++; $display("FAIL ldb_first got=y%0d pc%0d exp=y4 pc2", y_h, pc_h); end
      D = 8'hFF;
      tick();
      LD = 0;
      checks++; if (y_h !== 3'd0 || pc_h !== 4'd1 || v_h !== 1'b1) begin failures++; $display("FAIL ldb_ignored got=y%0d pc%0d v%0b exp=y0 pc1 v1", y_h, pc_h, v_h); end
      tick();
      checks++; if (done_h !== 1'b1) begin failures++; $display("FAIL ldb_done got=%0b exp=1", done_h); end
      LD = 1; D = 8'h02;
      tick();
      LD = 0;
      checks++; if (y_h !== 3'd1 || v_h !== 1'b1 || pc_h !== 4'd1 || rdy_h !== 1'b0) begin failures++; $display("FAIL ldb_done_load got=y%0d v%0b pc%0d r%0b exp=y1 v1 pc1 r0", y_h, v_h, pc_h, rdy_h); end
      for (int k = 0; k < 20 && !(rdy_h && rdy_l); k++) tick();
   endtask

   task automatic test_reset_mid();
      E = 1; RDY = 1; LD = 1; D = 8'hF0;
      tick();
      LD = 0;
      tick();
      checks++; if (y_h !== 3'd6 || pc_h !== 4'd3) begin failures++; $display("FAIL rmid_pre got=y%0d pc%0d exp=y6 pc3", y_h, pc_h); end
      rst = 1;
      tick();
      rst = 0;
      checks++; if (v_h !== 1'b0 || pc_h !== 4'd0 || rdy_h !== 1'b1 || done_h !== 1'b0) begin failures++; $display("FAIL rmid_abort got=v%0b pc%0d r%0b d%0b exp=v0 pc0 r1 d0", v_h, pc_h, rdy_h, done_h); end
      LD = 1; D = 8'h08;
      tick();
      LD = 0;
      checks++; if (y_h !== 3'd3 || v_h !== 1'b1 || pc_h !== 4'd1) begin failures++; $display("FAIL rmid_fresh got=y%0d v%0b pc%0d exp=y3 v1 pc1", y_h, v_h, pc_h); end
      tick();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 60) == 0);
         E   = ($urandom_range(0, 7) != 0);
         LD  = ($urandom_range(0, 3) == 0);
         D   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         RDY = ($urandom_range(0, 3) != 0);
         tick();
         for (int h = 0; h < 2; h++) begin
            logic [2:0] y; logic v, d, r; logic [3:0] pc;
            y = h ? y_h : y_l; v = h ? v_h : v_l; d = h ? done_h : done_l;
            r = h ? rdy_h : rdy_l; pc = h ? pc_h : pc_l;
            checks++;
            if (v !== m_v[h] || d !== m_done[h] || r !== !m_busy[h] ||
                pc !== 4'($countones(m_pend[h])) || (m_v[h] && y !== m_y[h])) begin
               failures++;
               if (errs < 10) $display("FAIL rand c%0d h%0d got=y%0d v%0b pc%0d d%0b r%0b exp=y%0d v%0b pc%0d d%0b r%0b",
                  c, h, y, v, pc, d, r, m_y[h], m_v[h], $countones(m_pend[h]), m_done[h], !m_busy[h]);
               errs++;
            end
         end
      end
      rst = 0; LD = 0;
   endtask

   initial begin
      rst = 1; E = 0; LD = 0; D = 8'h00; RDY = 0;
      test_reset();
      test_hi_a5();
      test_lo_stall();
      test_ignored_loads();
      test_enable_drop();
      test_ld_busy();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
